wb_regfile: RTL and testbench

Write-back stage plus architectural register file for the single-issue MIPS datapath. It consumes the final destination index produced by the destination-register select logic (`rd`, `rt`, or `$ra`), together with the result word and write enable from the MEM stage. It latches them in a MEM/WB pipeline register and commits them to a 32-entry register file one cycle later. Two combinational read ports serve the decode stage, with bypass from the pending write-back entry and `$zero` hardwired.

---
 rtl/wb_regfile.sv | 127 ++++++++++++
 tb/tb_wb_regfile.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// MEM/WB pipeline register and 32-entry architectural register file.
// Two combinational read ports bypass the pending write-back entry; $zero is hardwired.

package the_pkg;
    localparam int BR = 5;
endpackage

// One decode-stage read port: $zero, then pending-entry bypass, then array.
module wb_rf_rdport
    import the_pkg::*;
#(
    parameter int W    = 32,
    parameter int NREG = 2**BR
) (
    input  logic [BR-1:0]          ra,
    input  logic [NREG-1:0][W-1:0] rf,
    input  logic                   pend,
    input  logic [BR-1:0]          pend_rd,
    input  logic [W-1:0]           pend_data,
    output logic [W-1:0]           rd
);

    always_comb begin
        rd = rf[ra];
        if (ra == '0) begin
            rd = '0;
        end else if (pend && (pend_rd == ra)) begin
            rd = pend_data;
        end
    end

endmodule

module wb_regfile
    import the_pkg::*;
#(
    parameter int W    = 32,
    parameter int NREG = 2**BR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_en_in,
    input  logic [BR-1:0] wb_rd_in,
    input  logic [W-1:0]  wb_data_in,
    input  logic          stall,
    input  logic          flush,
    input  logic [BR-1:0] ra1,
    input  logic [BR-1:0] ra2,
    output logic [W-1:0]  rd1,
    output logic [W-1:0]  rd2,
    output logic          wb_pending,
    output logic [BR-1:0] wb_rd_q,
    output logic [W-1:0]  wb_count
);

    localparam int NRD = 2;

    typedef struct packed {
        logic          v;
        logic          en;
        logic [BR-1:0] rd;
        logic [W-1:0]  data;
    } mw_t;

    mw_t                   mw_q, mw_d;
    logic [NREG-1:0][W-1:0] rf_q, rf_d;
    logic [W-1:0]          cnt_q, cnt_d;
    logic                  commit;

    assign commit = mw_q.v & mw_q.en & (mw_q.rd != '0);

    always_comb begin
        mw_d  = mw_q;
        rf_d  = rf_q;
        cnt_d = cnt_q;
        // A stall freezes everything, including the flush of the incoming slot.
        if (!stall) begin
            if (commit) begin
                rf_d[mw_q.rd] = mw_q.data;
                cnt_d         = cnt_q + W'(1);
            end
            if (flush) begin
                mw_d = '0;
            end else begin
                mw_d.v    = 1'b1;
                mw_d.en   = wb_en_in;
                mw_d.rd   = wb_rd_in;
                mw_d.data = wb_data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mw_q  <= '0;
            rf_q  <= '0;
            cnt_q <= '0;
        end else begin
            mw_q  <= mw_d;
            rf_q  <= rf_d;
            cnt_q <= cnt_d;
        end
    end

    logic [NRD-1:0][BR-1:0] ra_v;
    logic [NRD-1:0][W-1:0]  rd_v;

    assign ra_v = {ra2, ra1};

    for (genvar g = 0; g < NRD; g++) begin : g_rp
        wb_rf_rdport #(.W(W), .NREG(NREG)) u_rp (
            .ra        (ra_v[g]),
            .rf        (rf_q),
            .pend      (commit),
            .pend_rd   (mw_q.rd),
            .pend_data (mw_q.data),
            .rd        (rd_v[g])
        );
    end

    assign rd1        = rd_v[0];
    assign rd2        = rd_v[1];
    assign wb_pending = commit;
    assign wb_rd_q    = mw_q.rd;
    assign wb_count   = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed cycle table plus a randomized phase scored against a reference model.

module tb_wb_regfile;
    import the_pkg::*;

    logic          clk, rst, wb_en_in, stall, flush;
    logic [BR-1:0] wb_rd_in, ra1, ra2, wb_rd_q;
    logic [31:0]   wb_data_in, rd1, rd2, wb_count;
    logic          wb_pending;

    int checks = 0;
    int errors = 0;

    wb_regfile #(.W(32), .NREG(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_en_in   (wb_en_in),
        .wb_rd_in   (wb_rd_in),
        .wb_data_in (wb_data_in),
        .stall      (stall),
        .flush      (flush),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .wb_pending (wb_pending),
        .wb_rd_q    (wb_rd_q),
        .wb_count   (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, flush, en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  ra1, ra2;
        logic [31:0] e1, e2;
        logic        ep;
        logic [4:0]  erdq;
        logic [31:0] ecnt;
    } vec_t;

    typedef struct {
        logic [31:0] e1, e2;
        logic        ep;
        logic [4:0]  erdq;
        logic [31:0] ecnt;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    // reference model state
    logic [31:0] m_rf[32];
    logic        m_v, m_en;
    logic [4:0]  m_rd;
    logic [31:0] m_data, m_cnt;

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0d got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic f, input logic en,
                       input logic [4:0] rd, input logic [31:0] data,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] e1, input logic [31:0] e2,
                       input logic ep, input logic [4:0] erdq, input logic [31:0] ecnt);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.en = en; v.rd = rd; v.data = data;
        v.ra1 = a1; v.ra2 = a2; v.e1 = e1; v.e2 = e2; v.ep = ep; v.erdq = erdq; v.ecnt = ecnt;
        tbl.push_back(v);
    endtask

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
            m_v = 0; m_en = 0; m_rd = '0; m_data = '0; m_cnt = '0;
        end else if (!stall) begin
            if (m_v && m_en && m_rd != 0) begin
                m_rf[m_rd] = m_data;
                m_cnt      = m_cnt + 1;
            end
            if (flush) begin
                m_v = 0; m_en = 0; m_rd = '0; m_data = '0;
            end else begin
                m_v = 1; m_en = wb_en_in; m_rd = wb_rd_in; m_data = wb_data_in;
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic pend;
        pend = m_v && m_en && (m_rd != 0);
        if (a == 0) return '0;
        if (pend && m_rd == a) return m_data;
        return m_rf[a];
    endfunction

    initial begin
        rst = 1; stall = 0; flush = 0; wb_en_in = 0; wb_rd_in = '0; wb_data_in = '0;
        ra1 = '0; ra2 = '0;

        //   rst st fl en rd  data          ra1 ra2  rd1           rd2           pend rdq cnt
        add(0, 0, 0, 1, 31, 32'h0040_0008, 31, 0,  32'h0,        32'h0,        0,   0,  0);
        add(0, 0, 0, 0, 0,  32'h0,         31, 31, 32'h0040_0008, 32'h0040_0008, 1,  31, 0);
        add(0, 0, 0, 0, 0,  32'h0,         31, 0,  32'h0040_0008, 32'h0,        0,   0,  1);
        add(0, 0, 0, 0, 0,  32'h0,         31, 0,  32'h0040_0008, 32'h0,        0,   0,  1);
        add(0, 0, 0, 1, 0,  32'hDEAD_BEEF, 0,  31, 32'h0,        32'h0040_0008, 0,   0,  1);
        add(0, 0, 0, 0, 0,  32'h0,         0,  31, 32'h0,        32'h0040_0008, 0,   0,  1);
        add(0, 0, 0, 0, 0,  32'h0,         0,  31, 32'h0,        32'h0040_0008, 0,   0,  1);
        add(0, 0, 0, 1, 8,  32'h11,        0,  8,  32'h0,        32'h0,        0,   0,  1);
        add(0, 0, 0, 1, 8,  32'h22,        0,  8,  32'h0,        32'h11,       1,   8,  1);
        add(0, 0, 0, 0, 0,  32'h0,         0,  8,  32'h0,        32'h22,       1,   8,  2);
        add(0, 0, 0, 0, 0,  32'h0,         0,  8,  32'h0,        32'h22,       0,   0,  3);
        add(0, 0, 0, 1, 9,  32'h55,        9,  8,  32'h0,        32'h22,       0,   0,  3);
        add(0, 1, 0, 0, 0,  32'h0,         9,  8,  32'h55,       32'h22,       1,   9,  3);
        add(0, 1, 0, 0, 0,  32'h0,         9,  8,  32'h55,       32'h22,       1,   9,  3);
        add(0, 1, 0, 0, 0,  32'h0,         9,  8,  32'h55,       32'h22,       1,   9,  3);
        add(0, 0, 0, 0, 0,  32'h0,         9,  8,  32'h55,       32'h22,       1,   9,  3);
        add(0, 0, 0, 0, 0,  32'h0,         9,  8,  32'h55,       32'h22,       0,   0,  4);
        add(0, 0, 0, 0, 0,  32'h0,         9,  8,  32'h55,       32'h22,       0,   0,  4);
        add(0, 0, 1, 1, 9,  32'h77,        9,  9,  32'h55,       32'h55,       0,   0,  4);
        add(0, 0, 0, 0, 0,  32'h0,         9,  9,  32'h55,       32'h55,       0,   0,  4);
        add(0, 0, 0, 0, 0,  32'h0,         9,  9,  32'h55,       32'h55,       0,   0,  4);
        add(0, 0, 0, 1, 5,  32'hA5,        5,  6,  32'h0,        32'h0,        0,   0,  4);
        add(0, 0, 1, 1, 6,  32'hB6,        5,  6,  32'hA5,       32'h0,        1,   5,  4);
        add(0, 0, 0, 0, 0,  32'h0,         5,  6,  32'hA5,       32'h0,        0,   0,  5);
        add(0, 0, 0, 1, 7,  32'hC7,        7,  5,  32'h0,        32'hA5,       0,   0,  5);
        add(0, 1, 1, 0, 0,  32'h0,         7,  5,  32'hC7,       32'hA5,       1,   7,  5);
        add(0, 0, 0, 0, 0,  32'h0,         7,  5,  32'hC7,       32'hA5,       1,   7,  5);
        add(0, 0, 0, 0, 0,  32'h0,         7,  5,  32'hC7,       32'hA5,       0,   0,  6);
        add(0, 0, 0, 1, 4,  32'h99,        4,  8,  32'h0,        32'h22,       0,   0,  6);
        add(1, 1, 1, 0, 0,  32'h0,         4,  8,  32'h99,       32'h22,       1,   4,  6);
        add(0, 0, 0, 0, 0,  32'h0,         4,  8,  32'h0,        32'h0,        0,   0,  0);
        add(0, 0, 0, 0, 0,  32'h0,         9,  31, 32'h0,        32'h0,        0,   0,  0);

        // reset state: every address reads zero on both ports
        repeat (2) @(posedge clk);
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            ra1 = 5'(a);
            ra2 = 5'(31 - a);
            #1;
            chk("rst_rd1", a, rd1, 32'h0);
            chk("rst_rd2", a, rd2, 32'h0);
        end
        chk("rst_pend", 0, {31'h0, wb_pending}, 32'h0);
        chk("rst_rdq",  0, {27'h0, wb_rd_q}, 32'h0);
        chk("rst_cnt",  0, wb_count, 32'h0);

        // directed table, one row per cycle
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            rst = tbl[i].rst; stall = tbl[i].stall; flush = tbl[i].flush;
            wb_en_in = tbl[i].en; wb_rd_in = tbl[i].rd; wb_data_in = tbl[i].data;
            ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
            @(negedge clk);
            chk("tbl_rd1",  i, rd1, tbl[i].e1);
            chk("tbl_rd2",  i, rd2, tbl[i].e2);
            chk("tbl_pend", i, {31'h0, wb_pending}, {31'h0, tbl[i].ep});
            chk("tbl_rdq",  i, {27'h0, wb_rd_q}, {27'h0, tbl[i].erdq});
            chk("tbl_cnt",  i, wb_count, tbl[i].ecnt);
        end

        // randomized phase: model advances on each edge, expectations queued at drive time
        @(posedge clk);
        #1;
        rst = 1; stall = 0; flush = 0;
        for (int i = 0; i < 400; i++) begin
            exp_t e;
            @(posedge clk);
            model_edge();
            #1;
            rst        = ($urandom_range(0, 79) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 5) == 0);
            wb_en_in   = ($urandom_range(0, 3) != 0);
            wb_rd_in   = 5'($urandom_range(0, 7));
            wb_data_in = $urandom;
            ra1        = 5'($urandom_range(0, 7));
            ra2        = 5'($urandom_range(0, 7));
            e.e1   = model_read(ra1);
            e.e2   = model_read(ra2);
            e.ep   = m_v && m_en && (m_rd != 0);
            e.erdq = m_rd;
            e.ecnt = m_cnt;
            exp_q.push_back(e);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty @%0d", i);
            end else begin
                e = exp_q.pop_front();
                chk("sb_rd1",  i, rd1, e.e1);
                chk("sb_rd2",  i, rd2, e.e2);
                chk("sb_pend", i, {31'h0, wb_pending}, {31'h0, e.ep});
                chk("sb_rdq",  i, {27'h0, wb_rd_q}, {27'h0, e.erdq});
                chk("sb_cnt",  i, wb_count, e.ecnt);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
